// File: rtl/or21nand_bist_pkg.sv
// Shared types and constants for the or21nand cell self-test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package or21nand_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Exhaustive stimulus for a 3-input cell.
    localparam int NUM_VEC = 8;
    localparam int VEC_W   = $clog2(NUM_VEC);

    // Mismatch counter width; the counter saturates at its all-ones value.
    localparam int                ERR_W   = 4;
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

endpackage

// File: rtl/or21nand_golden.sv
// Reference model of the or21nand cell: nq = ~((i0 | i1) & i2).
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: i0, i1, i2 - cell inputs; nq - expected cell output.
module or21nand_golden (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    output logic nq
);

    assign nq = ~((i0 | i1) & i2);

endmodule

// File: rtl/or21nand_bist.sv
// Built-in self-test for an or21nand cell: sweeps all 8 input vectors LOOPS times.
// Latency: LOOPS*8*(SETTLE+1) cycles from the accepted start edge to the done cycle.
// Backpressure: none; start is only accepted in IDLE and ignored otherwise.
// Ports: clk/rst (sync, active-high); start - run request; nq - cell output;
//        i0/i1/i2 - cell stimulus; busy/done - run status; pass, err_cnt,
//        fail_vld, fail_vec - result of the current or last run.
module or21nand_bist
    import or21nand_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned LOOPS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             nq,
    output logic             i0,
    output logic             i1,
    output logic             i2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_vld,
    output logic [VEC_W-1:0] fail_vec
);

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE);
    localparam logic [3:0]       LAST_LOOP   = 4'(LOOPS - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t             state_q,    state_d;
    logic [VEC_W-1:0]   vec_q,      vec_d;
    logic [3:0]         loop_q,     loop_d;
    logic [3:0]         settle_q,   settle_d;
    logic [ERR_W-1:0]   err_q,      err_d;
    logic               fail_vld_q, fail_vld_d;
    logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
    logic               pass_q,     pass_d;
    logic               exp_nq;

    // Drivers come straight from the vector register, so they only move on
    // edges that load a new vector, and the wrap 7->0 parks them at 0 for IDLE.
    or21nand_golden u_golden (
        .i0 (vec_q[0]),
        .i1 (vec_q[1]),
        .i2 (vec_q[2]),
        .nq (exp_nq)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        loop_d     = loop_q;
        settle_d   = settle_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d      = '0;
                    loop_d     = '0;
                    settle_d   = SETTLE_INIT;
                    err_d      = '0;
                    fail_vld_d = 1'b0;
                    fail_vec_d = '0;
                    pass_d     = 1'b0;
                    if (SETTLE == 0) state_d = SAMPLE;
                    else             state_d = WAIT;
                end
            end

            WAIT: begin
                settle_d = settle_q - 1'b1;
                if (settle_q <= 4'd1) state_d = SAMPLE;
            end

            SAMPLE: begin
                if (nq != exp_nq) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = vec_q;
                    end
                end
                vec_d    = vec_q + 1'b1;
                settle_d = SETTLE_INIT;
                if (SETTLE == 0) state_d = SAMPLE;
                else             state_d = WAIT;
                if (vec_q == LAST_VEC) begin
                    if (loop_q == LAST_LOOP) begin
                        state_d = DONE;
                        // Uses err_d so a mismatch on the very last vector counts.
                        pass_d  = (err_d == '0);
                    end else begin
                        loop_d = loop_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            loop_q     <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            loop_q     <= loop_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
            pass_q     <= pass_d;
        end
    end

    assign i0       = vec_q[0];
    assign i1       = vec_q[1];
    assign i2       = vec_q[2];
    assign busy     = (state_q == WAIT) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vld = fail_vld_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_or21nand_bist.sv
// Directed bench for or21nand_bist over five parameter sets sharing clk/rst/start.
// Instances: 0 defaults, 1 SETTLE=3, 2 LOOPS=2, 3 LOOPS=4, 4 SETTLE=0.
// The cell model per instance is good, stuck-at-1 or stuck-at-0 by mode.
module tb_or21nand_bist;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    int         mode;

    logic       nq       [N];
    logic       i0       [N];
    logic       i1       [N];
    logic       i2       [N];
    logic       busy     [N];
    logic       done     [N];
    logic       pass     [N];
    logic [3:0] err_cnt  [N];
    logic       fail_vld [N];
    logic [2:0] fail_vec [N];

    int n_chk = 0;
    int n_err = 0;

    int dcyc  [N];
    int dcnt  [N];
    int dbusy [N];
    int stab_bad;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            if (mode == 1)      nq[k] = 1'b1;
            else if (mode == 2) nq[k] = 1'b0;
            else                nq[k] = ~((i0[k] | i1[k]) & i2[k]);
        end
    end

    or21nand_bist #(.SETTLE(1), .LOOPS(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .nq(nq[0]),
        .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_cnt(err_cnt[0]), .fail_vld(fail_vld[0]), .fail_vec(fail_vec[0]));

    or21nand_bist #(.SETTLE(3), .LOOPS(1)) u_dut_s3 (
        .clk(clk), .rst(rst), .start(start), .nq(nq[1]),
        .i0(i0[1]), .i1(i1[1]), .i2(i2[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_cnt(err_cnt[1]), .fail_vld(fail_vld[1]), .fail_vec(fail_vec[1]));

    or21nand_bist #(.SETTLE(1), .LOOPS(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .start(start), .nq(nq[2]),
        .i0(i0[2]), .i1(i1[2]), .i2(i2[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_cnt(err_cnt[2]), .fail_vld(fail_vld[2]), .fail_vec(fail_vec[2]));

    or21nand_bist #(.SETTLE(1), .LOOPS(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .start(start), .nq(nq[3]),
        .i0(i0[3]), .i1(i1[3]), .i2(i2[3]), .busy(busy[3]), .done(done[3]),
        .pass(pass[3]), .err_cnt(err_cnt[3]), .fail_vld(fail_vld[3]), .fail_vec(fail_vec[3]));

    or21nand_bist #(.SETTLE(0), .LOOPS(1)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start), .nq(nq[4]),
        .i0(i0[4]), .i1(i1[4]), .i2(i2[4]), .busy(busy[4]), .done(done[4]),
        .pass(pass[4]), .err_cnt(err_cnt[4]), .fail_vld(fail_vld[4]), .fail_vec(fail_vec[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then observe cycles 0..99 after the start edge. Cycle c is
    // the interval following edge c. Optional reset and extra start pulses.
    task automatic run(input int rst_at, input int s1, input int s2);
        for (int k = 0; k < N; k++) begin
            dcyc[k]  = -1;
            dcnt[k]  = 0;
            dbusy[k] = 0;
        end
        stab_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_at_c0",   32'(busy[0]),    1);
        chk("pass_cleared", 32'(pass[0]),    0);
        chk("err_cleared",  32'(err_cnt[0]), 0);
        for (int c = 0; c < 100; c++) begin
            for (int k = 0; k < N; k++) begin
                if (done[k] === 1'b1) begin
                    dcnt[k]++;
                    if (dcyc[k] < 0) dcyc[k] = c;
                    if (busy[k] !== 1'b0) dbusy[k]++;
                end
            end
            if (c < 16 && {i2[0], i1[0], i0[0]} !== 3'((c / 2) % 8)) stab_bad++;
            if (c < 32 && {i2[1], i1[1], i0[1]} !== 3'((c / 4) % 8)) stab_bad++;
            if (c == rst_at) begin
                chk("err_before_rst",  32'(err_cnt[0]),  3);
                chk("fvld_before_rst", 32'(fail_vld[0]), 1);
                rst = 1'b1;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst_busy",  32'(busy[0]),     0);
                chk("rst_done",  32'(done[0]),     0);
                chk("rst_pass",  32'(pass[0]),     0);
                chk("rst_err",   32'(err_cnt[0]),  0);
                chk("rst_fvld",  32'(fail_vld[0]), 0);
                chk("rst_fvec",  32'(fail_vec[0]), 0);
                chk("rst_vec",   32'({i2[0], i1[0], i0[0]}), 0);
                chk("rst_busy3", 32'(busy[3]),     0);
                rst = 1'b0;
            end
            start = (c == s1) || (c == s2);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tick();
        tick();
        chk("reset_busy", 32'(busy[0]),     0);
        chk("reset_done", 32'(done[0]),     0);
        chk("reset_pass", 32'(pass[0]),     0);
        chk("reset_err",  32'(err_cnt[0]),  0);
        chk("reset_fvld", 32'(fail_vld[0]), 0);
        chk("reset_fvec", 32'(fail_vec[0]), 0);
        chk("reset_vec",  32'({i2[0], i1[0], i0[0]}), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy[0]), 0);

        // Good cell on every parameter set.
        mode = 0;
        run(-1, -1, -1);
        chk("good_done_cyc_def", dcyc[0], 16);
        chk("good_done_cyc_s3",  dcyc[1], 32);
        chk("good_done_cyc_l2",  dcyc[2], 32);
        chk("good_done_cyc_l4",  dcyc[3], 64);
        chk("good_done_cyc_s0",  dcyc[4], 8);
        chk("good_done_cnt",     dcnt[0], 1);
        chk("busy_in_done",      dbusy[0], 0);
        chk("driver_stability",  stab_bad, 0);
        chk("good_pass",         32'(pass[0]),     1);
        chk("good_pass_s3",      32'(pass[1]),     1);
        chk("good_pass_l4",      32'(pass[3]),     1);
        chk("good_err",          32'(err_cnt[0]),  0);
        chk("good_fvld",         32'(fail_vld[0]), 0);
        chk("idle_vec",          32'({i2[0], i1[0], i0[0]}), 0);

        // Stuck-at-1: vectors 5,6,7 expect 0.
        mode = 1;
        run(-1, -1, -1);
        chk("s1_done_cyc", dcyc[0], 16);
        chk("s1_err",      32'(err_cnt[0]),  3);
        chk("s1_fvld",     32'(fail_vld[0]), 1);
        chk("s1_fvec",     32'(fail_vec[0]), 5);
        chk("s1_pass",     32'(pass[0]),     0);
        chk("s1_err_l2",   32'(err_cnt[2]),  6);

        // Stuck-at-0: vectors 0..4 expect 1.
        mode = 2;
        run(-1, -1, -1);
        chk("s0_err",      32'(err_cnt[0]),  5);
        chk("s0_fvec",     32'(fail_vec[0]), 0);
        chk("s0_fvld",     32'(fail_vld[0]), 1);
        chk("s0_pass",     32'(pass[0]),     0);
        chk("s0_err_s3",   32'(err_cnt[1]),  5);
        chk("s0_err_l2",   32'(err_cnt[2]),  10);
        chk("s0_err_l4",   32'(err_cnt[3]),  15);

        // Start re-pulsed mid-run and in the DONE cycle.
        mode = 0;
        run(-1, 3, 16);
        chk("restart_done_cnt", dcnt[0], 1);
        chk("restart_done_cyc", dcyc[0], 16);
        chk("restart_pass",     32'(pass[0]), 1);

        // Reset during cycle 7 of a failing run.
        mode = 2;
        run(7, -1, -1);
        for (int k = 0; k < N; k++) chk($sformatf("abort_no_done_%0d", k), dcnt[k], 0);

        // A later run behaves normally.
        mode = 0;
        run(-1, -1, -1);
        chk("after_rst_done_cyc", dcyc[0], 16);
        chk("after_rst_pass",     32'(pass[0]),    1);
        chk("after_rst_err",      32'(err_cnt[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
